// File: rtl/add_seq_ctrl.sv
// Multi-cycle wide add/subtract built on a single ChunkWidth-bit adder.
// Operands are processed LSB chunk first; C, Z and V flags follow AVR conventions.
module add_seq_ctrl #(
    parameter int DataWidth  = 32,
    parameter int ChunkWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DataWidth-1:0] req_a,
    input  logic [DataWidth-1:0] req_b,
    input  logic                 req_sub,
    input  logic                 req_use_ci,
    input  logic                 req_ci,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DataWidth-1:0] res_s,
    output logic                 res_co,
    output logic                 res_z,
    output logic                 res_v
);

    localparam int NumChunks = DataWidth / ChunkWidth;
    localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] LastK = CntW'(NumChunks - 1);

    if ((ChunkWidth < 1) || (DataWidth % ChunkWidth != 0)) begin : g_bad_width
        $error("add_seq_ctrl: DataWidth must be a multiple of ChunkWidth");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q;
    logic [CntW-1:0]        k_q;
    logic                   c_q;
    logic                   sub_q;
    logic                   req_ready_q;
    logic                   res_valid_q;
    logic [DataWidth-1:0]   res_s_q;
    logic                   res_co_q;
    logic                   res_z_q;
    logic                   res_v_q;

    // Operand registers shift right so the active chunk is always in the low bits.
    logic [DataWidth-1:0]   a_q;
    logic [DataWidth-1:0]   b_q;
    logic [DataWidth-1:0]   s_acc_q;
    logic [DataWidth-1:0]   s_acc_d;
    logic [ChunkWidth:0]    chunk_sum;
    logic                   v_d;

    always_comb begin
        chunk_sum = {1'b0, a_q[ChunkWidth-1:0]} + {1'b0, b_q[ChunkWidth-1:0]}
                  + {{ChunkWidth{1'b0}}, c_q};
        s_acc_d = s_acc_q;
        s_acc_d[int'(k_q)*ChunkWidth +: ChunkWidth] = chunk_sum[ChunkWidth-1:0];
        v_d = (a_q[ChunkWidth-1] == b_q[ChunkWidth-1]) &&
              (chunk_sum[ChunkWidth-1] != a_q[ChunkWidth-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= 1'b0;
            sub_q       <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_co_q    <= 1'b0;
            res_z_q     <= 1'b0;
            res_v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        // Subtraction is A + ~B + 1, so an incoming borrow clears the carry.
                        c_q         <= req_sub ^ (req_use_ci & req_ci);
                        sub_q       <= req_sub;
                        k_q         <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    c_q <= chunk_sum[ChunkWidth];
                    k_q <= k_q + CntW'(1);
                    if (k_q == LastK) begin
                        res_s_q     <= s_acc_d;
                        res_co_q    <= sub_q ^ chunk_sum[ChunkWidth];
                        res_z_q     <= (s_acc_d == '0);
                        res_v_q     <= v_d;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            a_q <= req_a;
            b_q <= req_sub ? ~req_b : req_b;
        end else if (state_q == BUSY) begin
            a_q     <= a_q >> ChunkWidth;
            b_q     <= b_q >> ChunkWidth;
            s_acc_q <= s_acc_d;
        end
    end

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_co    = res_co_q;
    assign res_z     = res_z_q;
    assign res_v     = res_v_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: a 32/8 instance with directed and random
// traffic and a 16/16 instance with random traffic, both against a wide-arithmetic model.
module tb_add_seq_ctrl;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        z;
        logic        v;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // 32-bit / 8-bit chunk instance
    logic        req_valid = 0, req_sub = 0, req_use_ci = 0, req_ci = 0, res_ready = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic        req_ready, res_valid, res_co, res_z, res_v;
    logic [31:0] res_s;

    // 16-bit / 16-bit chunk instance
    logic        req_valid1 = 0, req_sub1 = 0, req_use_ci1 = 0, req_ci1 = 0, res_ready1 = 0;
    logic [15:0] req_a1 = 0, req_b1 = 0;
    logic        req_ready1, res_valid1, res_co1, res_z1, res_v1;
    logic [15:0] res_s1;

    exp_t q0[$];
    exp_t q1[$];
    bit   rr_rand = 0;
    bit   done1 = 0;

    add_seq_ctrl #(.DataWidth(32), .ChunkWidth(8)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_use_ci(req_use_ci),
        .req_ci(req_ci), .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
        .res_co(res_co), .res_z(res_z), .res_v(res_v)
    );

    add_seq_ctrl #(.DataWidth(16), .ChunkWidth(16)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_sub(req_sub1), .req_use_ci(req_use_ci1),
        .req_ci(req_ci1), .res_valid(res_valid1), .res_ready(res_ready1), .res_s(res_s1),
        .res_co(res_co1), .res_z(res_z1), .res_v(res_v1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: plain wide integer arithmetic on w-bit operands.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                   logic sub, logic use_ci, logic ci);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint aa = longint'({32'd0, a}) & mask;
        longint bb = longint'({32'd0, b}) & mask;
        int     cin = (use_ci && ci) ? 1 : 0;
        longint r;
        logic   sa, sb, ss;
        r = sub ? (aa - bb - cin) : (aa + bb + cin);
        e.s = 32'(r & mask);
        e.co = sub ? (r < 0) : (((r >> w) & 1) != 0);
        e.z = (e.s == 0);
        sa = a[w-1];
        sb = b[w-1];
        ss = e.s[w-1];
        e.v = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        e.acc = 0;
        return e;
    endfunction

    task automatic compare(string tag, int n, logic [31:0] s, logic co, logic z, logic v, exp_t e);
        check({tag, "_s"}, s, e.s);
        check({tag, "_co"}, co, e.co);
        check({tag, "_z"}, z, e.z);
        check({tag, "_v"}, v, e.v);
        check({tag, "_latency"}, cyc - e.acc, n);
    endtask

    // Monitors: compare each newly presented result with the oldest expectation.
    bit   seen0 = 0, seen1 = 0;
    exp_t m0, m1;
    always @(negedge clk) begin
        if (res_valid && !seen0) begin
            seen0 = 1;
            if (q0.size() == 0) check("dut0_unexpected_result", 1, 0);
            else begin
                m0 = q0.pop_front();
                compare("dut0", 4, res_s, res_co, res_z, res_v, m0);
            end
        end else if (!res_valid) seen0 = 0;
    end

    always @(negedge clk) begin
        if (res_valid1 && !seen1) begin
            seen1 = 1;
            if (q1.size() == 0) check("dut1_unexpected_result", 1, 0);
            else begin
                m1 = q1.pop_front();
                compare("dut1", 1, {16'd0, res_s1}, res_co1, res_z1, res_v1, m1);
            end
        end else if (!res_valid1) seen1 = 0;
    end

    always @(negedge clk) begin
        if (rr_rand) res_ready = 1'($urandom);
        res_ready1 = 1'($urandom);
    end

    task automatic issue(logic [31:0] a, logic [31:0] b, logic sub, logic uci, logic ci, bit push);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        req_a = a; req_b = b; req_sub = sub; req_use_ci = uci; req_ci = ci;
        req_valid = 1;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("dut0_accept_timeout", 0, 1);
            req_valid = 0;
            return;
        end
        if (push) begin
            e = model(32, a, b, sub, uci, ci);
            e.acc = cyc + 1;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble inputs while busy; they must not matter.
        req_valid = 0; req_a = $urandom; req_b = $urandom;
        req_sub = 1'($urandom); req_use_ci = 1'($urandom); req_ci = 1'($urandom);
    endtask

    task automatic wait_idle(string nm);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check({nm, "_idle_timeout"}, 0, 1);
    endtask

    task automatic expect_lit(string nm, logic [31:0] s, logic co, logic z, logic v);
        check({nm, "_s"}, res_s, s);
        check({nm, "_co"}, res_co, co);
        check({nm, "_z"}, res_z, z);
        check({nm, "_v"}, res_v, v);
    endtask

    // Random traffic on the single-chunk instance.
    initial begin
        exp_t e;
        int   t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_a1 = 16'($urandom); req_b1 = 16'($urandom);
            req_sub1 = 1'($urandom); req_use_ci1 = 1'($urandom); req_ci1 = 1'($urandom);
            req_valid1 = 1;
            t = 0;
            while (!req_ready1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!req_ready1) begin
                check("dut1_accept_timeout", 0, 1);
                break;
            end
            e = model(16, {16'd0, req_a1}, {16'd0, req_b1}, req_sub1, req_use_ci1, req_ci1);
            e.acc = cyc + 1;
            q1.push_back(e);
            @(posedge clk);
            #1;
            req_valid1 = 0; req_a1 = 16'($urandom); req_b1 = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        done1 = 1;
    end

    initial begin
        logic [31:0] snap_s;
        logic        snap_co, snap_z, snap_v;
        exp_t        e;
        int          t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_res_valid", res_valid, 0);
        expect_lit("reset", 32'h0, 0, 0, 0);
        rst = 0;

        // Directed cases, consumer always ready.
        res_ready = 1;
        issue(32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 1);
        wait_idle("wrap");
        expect_lit("add_wrap", 32'h00000000, 1, 1, 0);
        issue(32'h00000000, 32'h00000001, 1, 0, 0, 1);
        wait_idle("borrow");
        expect_lit("sub_borrow", 32'hFFFFFFFF, 1, 0, 0);
        issue(32'h80000000, 32'h00000001, 1, 0, 0, 1);
        wait_idle("subv");
        expect_lit("sub_ovf", 32'h7FFFFFFF, 0, 0, 1);
        issue(32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 1);
        wait_idle("addv");
        expect_lit("add_ovf", 32'h80000000, 0, 0, 1);
        issue(32'h00000005, 32'h00000005, 1, 1, 1, 1);
        wait_idle("sbc");
        expect_lit("sbc_chain", 32'hFFFFFFFF, 1, 0, 0);

        // Backpressure in DONE with a waiting request.
        @(negedge clk);
        res_ready = 0;
        issue(32'h12345678, 32'h0FEDCBA9, 0, 1, 1, 1);
        t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_result_seen", res_valid, 1);
        req_a = 32'h3; req_b = 32'h4; req_sub = 0; req_use_ci = 0; req_ci = 0;
        req_valid = 1;
        snap_s = res_s; snap_co = res_co; snap_z = res_z; snap_v = res_v;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req_ready_low", req_ready, 0);
            check("bp_res_valid_held", res_valid, 1);
            check("bp_res_stable", {res_s, res_co, res_z, res_v}, {snap_s, snap_co, snap_z, snap_v});
        end
        res_ready = 1;
        @(negedge clk);
        check("bp_release_valid_low", res_valid, 0);
        check("bp_release_ready_high", req_ready, 1);
        expect_lit("bp_persist", snap_s, snap_co, snap_z, snap_v);
        e = model(32, 32'h3, 32'h4, 0, 0, 0);
        e.acc = cyc + 1;
        q0.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 0;
        wait_idle("bp_next");

        // Reset while chunk 2 is being processed.
        issue(32'hDEADBEEF, 32'h01234567, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_valid", res_valid, 0);
        end
        issue(32'h00010001, 32'hFFFF0000, 0, 0, 0, 1);
        wait_idle("post_rst");

        // Random regression with throttled consumer.
        rr_rand = 1;
        for (int i = 0; i < 40; i++) begin
            issue($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !done1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_dut0_queue", q0.size(), 0);
        check("drain_dut1_queue", q1.size(), 0);
        check("dut1_done", done1, 1);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
